// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
//
// Bundles every handshake and RAM-port signal of ram_port_arbiter so the
// arbiter and its environment connect through one port.
//
// Signal groups:
//   preload_req / preload_done          : RAM preload strobe request / pulse
//   a_* / b_*                           : requester A (CPU) and B (loader)
//       req, we, addr, wdata            : request side, held until gnt
//       gnt, done, rdata                : one-cycle accept / complete pulses,
//                                         read result
//   ram_address, ram_we, ram_dataIn,
//   ram_testStart                       : arbiter -> RAM_8bits inputs
//   ram_dataOut                         : RAM_8bits -> arbiter read data
//
// Modports:
//   slave  : the arbiter side
//   master : the environment side (requesters and the RAM instance)
//
// Handshake: a requester raises req with we/addr/wdata stable and holds all
// of them until it sees gnt for one cycle; the fields are sampled on the
// edge that starts the gnt cycle. After gnt, req may drop. done pulses for
// one cycle when the transaction has completed; for a read, rdata is valid
// from that cycle on and holds until the requester's next read completes.
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              preload_req;
    logic              preload_done;

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_done;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_done;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] ram_address;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dataIn;
    logic              ram_testStart;
    logic [DATA_W-1:0] ram_dataOut;

    modport slave (
        input  preload_req,
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_dataOut,
        output preload_done,
        output a_gnt, a_done, a_rdata,
        output b_gnt, b_done, b_rdata,
        output ram_address, ram_we, ram_dataIn, ram_testStart
    );

    modport master (
        output preload_req,
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_dataOut,
        input  preload_done,
        input  a_gnt, a_done, a_rdata,
        input  b_gnt, b_done, b_rdata,
        input  ram_address, ram_we, ram_dataIn, ram_testStart
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Sequencer and two-requester arbiter for the single-port 32x8 RAM_8bits.
// Serialises read/write transactions from requester A (CPU) and requester B
// (loader/debug) onto the RAM port, returns read data with a done pulse and
// issues the RAM's testStart preload strobe on request. It is the only
// driver of the RAM's address, dataIn, WE and testStart inputs.
//
// Ports:
//   clock      : system clock, all logic on posedge
//   reset_n    : synchronous active-low reset
//   bus        : ram_port_arbiter_if.slave (requesters, preload, RAM port)
//   dbg_state  : current FSM state (0 IDLE, 1 PRELOAD, 2 ACCESS, 3 RESP)
//
// Configuration macro:
//   RAM_ARB_RR_EN : when defined, A/B contention is resolved round-robin
//                   (the requester not served last wins; after reset A wins
//                   first). When undefined, A always beats B and the
//                   round-robin pointer does not exist.
//
// Sequence per transaction (one outstanding at a time):
//   IDLE --preload_req--> PRELOAD (testStart=1 one cycle) --> IDLE,
//                                  preload_done pulses after it.
//   IDLE --a_req|b_req--> ACCESS  (gnt, RAM driven one cycle)
//        write: --> IDLE, done pulses after it
//        read : --> RESP (address held, RAM output stable)
//               --> IDLE, rdata captured and done pulses after it
// preload_req outranks both requesters; a losing requester stays pending.
// All outputs are registered.
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    ram_port_arbiter_if.slave      bus,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRELOAD = 2'd1,
        S_ACCESS  = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t            state;

    // Which requester owns the transaction in flight (1 = B).
    logic              owner_b;

    // Latched RAM-port drive registers.
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              test_q;

    // Registered pulses and read results.
    logic              a_gnt_q;
    logic              b_gnt_q;
    logic              a_done_q;
    logic              b_done_q;
    logic              preload_done_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // Arbitration result for the IDLE cycle: 1 selects B. Only meaningful
    // when at least one request is present.
    logic              pick_b;

`ifdef RAM_ARB_RR_EN
    // 1 = B was served last. Reset value makes the first contention go to A.
    logic              last_b;

    // On contention, B wins only if A was the last one served.
    assign pick_b = bus.b_req & (~bus.a_req | ~last_b);
`else
    // Fixed priority: B is chosen only when A is not requesting.
    assign pick_b = bus.b_req & ~bus.a_req;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            owner_b        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            we_q           <= 1'b0;
            test_q         <= 1'b0;
            a_gnt_q        <= 1'b0;
            b_gnt_q        <= 1'b0;
            a_done_q       <= 1'b0;
            b_done_q       <= 1'b0;
            preload_done_q <= 1'b0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
`ifdef RAM_ARB_RR_EN
            last_b         <= 1'b1;
`endif
        end else begin
            // Pulses default low; each state raises the ones it owns.
            a_gnt_q        <= 1'b0;
            b_gnt_q        <= 1'b0;
            a_done_q       <= 1'b0;
            b_done_q       <= 1'b0;
            preload_done_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.preload_req) begin
                        // Preload outranks requesters; they stay pending.
                        state  <= S_PRELOAD;
                        test_q <= 1'b1;
                        we_q   <= 1'b0;
                    end else if (bus.a_req || bus.b_req) begin
                        state   <= S_ACCESS;
                        owner_b <= pick_b;
                        if (pick_b) begin
                            we_q    <= bus.b_we;
                            addr_q  <= bus.b_addr;
                            wdata_q <= bus.b_wdata;
                            b_gnt_q <= 1'b1;
                        end else begin
                            we_q    <= bus.a_we;
                            addr_q  <= bus.a_addr;
                            wdata_q <= bus.a_wdata;
                            a_gnt_q <= 1'b1;
                        end
`ifdef RAM_ARB_RR_EN
                        last_b  <= pick_b;
`endif
                    end
                end

                S_PRELOAD: begin
                    // RAM loads its image on this exiting edge.
                    test_q         <= 1'b0;
                    preload_done_q <= 1'b1;
                    state          <= S_IDLE;
                end

                S_ACCESS: begin
                    // RAM performs the write or captures the read here.
                    we_q <= 1'b0;
                    if (we_q) begin
                        state    <= S_IDLE;
                        a_done_q <= ~owner_b;
                        b_done_q <= owner_b;
                    end else begin
                        state <= S_RESP;
                    end
                end

                S_RESP: begin
                    // addr_q is untouched, so ram_dataOut is stable here.
                    if (owner_b) begin
                        b_rdata_q <= bus.ram_dataOut;
                        b_done_q  <= 1'b1;
                    end else begin
                        a_rdata_q <= bus.ram_dataOut;
                        a_done_q  <= 1'b1;
                    end
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ram_address   = addr_q;
    assign bus.ram_dataIn    = wdata_q;
    assign bus.ram_we        = we_q;
    assign bus.ram_testStart = test_q;
    assign bus.a_gnt         = a_gnt_q;
    assign bus.b_gnt         = b_gnt_q;
    assign bus.a_done        = a_done_q;
    assign bus.b_done        = b_done_q;
    assign bus.preload_done  = preload_done_q;
    assign bus.a_rdata       = a_rdata_q;
    assign bus.b_rdata       = b_rdata_q;
    assign dbg_state         = state;

endmodule
